// File: rtl/pc_seq_if.sv
// pc_seq_if: bus bundle between a PC sequencer and whatever drives it.
// There is no valid/ready handshake on this bus. enable is a qualifier
// sampled on every rising clock edge: when it is high the sequencer consumes
// pc_src/offset/target/call in that cycle, and there is no backpressure.
// q and the RAS status flags are registered outputs that change one clock
// after the inputs that caused the change.
interface pc_seq_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic [1:0]       pc_src;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] target;
  logic             call;
  logic [WIDTH-1:0] q;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;
  logic             misalign;

  modport master (
    output enable, pc_src, offset, target, call,
    input  q, ras_empty, ras_full, ras_err, misalign
  );

  modport slave (
    input  enable, pc_src, offset, target, call,
    output q, ras_empty, ras_full, ras_err, misalign
  );
endinterface

// File: rtl/pc_seq.sv
// pc_seq: program counter sequencer with optional return-address stack.
// Next PC is sequential, PC-relative branch, absolute jump or return.
// Optional feature macro: PC_SEQ_RAS_EN enables the return-address stack.
// Without it, return behaves as a jump to target and call is ignored.
module pc_seq #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input logic    Clk,
  input logic    Rst,
  pc_seq_if.slave bus
);

  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INC - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] next_raw;
  logic             is_ret;

  assign seq_pc = q_q + INC_W;
  assign is_ret = (bus.pc_src == 2'b11);

`ifdef PC_SEQ_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // Circular storage: ptr_q indexes the top entry; pushes past the end wrap
  // onto the oldest entry, which is exactly the overflow-overwrite behaviour.
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;
  logic             ras_we;
  logic [PTR_W-1:0] ras_wa;
  logic [WIDTH-1:0] ras_top;
  logic             empty_w, full_w;

  assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;
  assign ras_top = ras_mem_q[ptr_q];
  assign empty_w = (cnt_q == '0);
  assign full_w  = (cnt_q == CNT_FULL);
`else
  logic unused_call;
  assign unused_call = bus.call;
`endif

  // Next-PC select, alignment, misalign flag and RAS push/pop bookkeeping.
  always_comb begin
    q_d        = q_q;
    misalign_d = 1'b0;
    next_raw   = seq_pc;
`ifdef PC_SEQ_RAS_EN
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    ras_we = 1'b0;
    ras_wa = ptr_q;
`endif
    if (bus.enable) begin
      unique case (bus.pc_src)
        2'b00: next_raw = seq_pc;
        2'b01: next_raw = q_q + bus.offset;
        2'b10: next_raw = bus.target;
        default: begin
`ifdef PC_SEQ_RAS_EN
          // An empty stack cannot supply a return address: fall through.
          next_raw = empty_w ? seq_pc : ras_top;
`else
          next_raw = bus.target;
`endif
        end
      endcase
`ifdef PC_SEQ_RAS_EN
      if (is_ret && bus.call) begin
        // Return and call together: top is consumed then replaced in place.
        if (empty_w) begin
          ptr_d  = ptr_inc;
          ras_wa = ptr_inc;
          cnt_d  = CNT_W'(1);
          err_d  = 1'b1;
        end else begin
          ras_wa = ptr_q;
        end
        ras_we = 1'b1;
      end else if (is_ret) begin
        if (empty_w) begin
          err_d = 1'b1;
        end else begin
          ptr_d = ptr_dec;
          cnt_d = cnt_q - 1'b1;
        end
      end else if (bus.call) begin
        ptr_d  = ptr_inc;
        ras_wa = ptr_inc;
        ras_we = 1'b1;
        if (full_w) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      q_d        = next_raw & ~LOW_MASK;
      misalign_d = |(next_raw & LOW_MASK);
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_q        <= RESET_VECTOR;
      misalign_q <= 1'b0;
`ifdef PC_SEQ_RAS_EN
      ptr_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      q_q        <= q_d;
      misalign_q <= misalign_d;
`ifdef PC_SEQ_RAS_EN
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

`ifdef PC_SEQ_RAS_EN
  // Return-address storage; contents are not cleared by reset.
  always_ff @(posedge Clk) begin
    if (!Rst && ras_we) begin
      ras_mem_q[ras_wa] <= seq_pc;
    end
  end

  assign bus.ras_empty = empty_w;
  assign bus.ras_full  = full_w;
  assign bus.ras_err   = err_q;
`else
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_err   = 1'b0;
`endif

  assign bus.q        = q_q;
  assign bus.misalign = misalign_q;

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter WIDTH, 32, PC/address width in bits (>=8).
REQ-002 SHALL have parameter RESET_VECTOR, 32'h00000000, PC value loaded on reset (WIDTH bits, word-aligned).
REQ-003 SHALL have parameter INC, 4, sequential increment in bytes (power of two).
REQ-004 SHALL have parameter RAS_DEPTH, 4, return-address-stack entries (2..16).
REQ-005 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port enable  input  1  advance PC when high; hold all state when low.
REQ-008 SHALL have port pc_src  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 return.
REQ-009 SHALL have port offset  input  WIDTH  signed two's-complement byte offset for branch.
REQ-010 SHALL have port target  input  WIDTH  absolute jump address.
REQ-011 SHALL have port call  input  1  push q+INC onto RAS this advance.
REQ-012 SHALL have port q  output  WIDTH  current PC (registered).
REQ-013 SHALL have port ras_empty  output  1  RAS holds zero entries.
REQ-014 SHALL have port ras_full  output  1  RAS holds RAS_DEPTH entries.
REQ-015 SHALL have port ras_err  output  1  sticky: RAS overflow or underflow since reset.
REQ-016 SHALL have port misalign  output  1  one-cycle pulse: last loaded address had nonzero bits below log2(INC).

Function
REQ-017 On a rising edge with enable=1, q SHALL load next: 00 q+INC; 01 q+offset; 10 target; 11 RAS top.
REQ-018 All arithmetic SHALL be modulo 2^WIDTH; wrap-around from max address to 0 SHALL be silent.
REQ-019 The loaded address SHALL have bits below log2(INC) forced to 0; misalign SHALL be 1 for exactly the cycle after such a load when those bits were nonzero, else 0.
REQ-020 With enable=0, q, RAS contents, count and ras_err SHALL hold; misalign SHALL be 0; pc_src/call SHALL be ignored.
REQ-021 RAS SHALL be a LIFO with count 0..RAS_DEPTH; call alone SHALL push q+INC (pre-update q), count+1.
REQ-022 pc_src=11 alone SHALL pop: next q = top entry, count-1.
REQ-023 Push when full SHALL overwrite the oldest entry (circular), count stays RAS_DEPTH, ras_err set.
REQ-024 Pop when empty SHALL load q+INC, count stays 0, ras_err set.
REQ-025 call with pc_src=11 simultaneously SHALL use old top as next q and replace top with q+INC; count unchanged; if empty, treat as underflow (q+INC loaded, then push, count=1, ras_err set).
REQ-026 call with pc_src 00/01/10 SHALL push and take the selected next PC in the same cycle.
REQ-027 ras_empty/ras_full SHALL be combinational decodes of registered count; latency of every state change SHALL be one clock.

Reset
REQ-028 With Rst=1 at a rising edge, q SHALL become RESET_VECTOR, count 0, ras_err 0, misalign 0, regardless of enable.
REQ-029 Reset SHALL take priority over all other inputs, including mid-sequence call/return; RAS entry contents need not be cleared.
REQ-030 Outputs SHALL be undefined only before the first reset edge.

Configuration
REQ-031 Macro PC_SEQ_RAS_EN defined: RAS, call, ras_empty, ras_full, ras_err behave per REQ-021..REQ-026.
REQ-032 PC_SEQ_RAS_EN undefined: no RAS storage; pc_src=11 SHALL behave as 10 (jump to target); call ignored; ras_empty=1, ras_full=0, ras_err=0 constant; ports retained.

Verification
REQ-033 Rst=1 one edge, then enable=1, pc_src=00 for 3 edges -> q: 0x0, 0x4, 0x8, 0xC.
REQ-034 q=0x100, pc_src=01, offset=0xFFFFFFF0 -> q=0xF0; q=0xFFFFFFFC, pc_src=00 -> q=0x0.
REQ-035 q=0x200 call with pc_src=10 target=0x800 -> q=0x800; then pc_src=11 -> q=0x204, ras_empty=1, ras_err=0.
REQ-036 RAS_DEPTH=4: 5 calls from 0x10,0x20,0x30,0x40,0x50 -> ras_full=1, ras_err=1; 4 returns -> 0x54,0x44,0x34,0x24; 5th return -> q+4, ras_err stays 1.
REQ-037 pc_src=10 target=0x1003 -> q=0x1000, misalign=1 for one cycle; enable=0 with pc_src=11 for 3 edges -> q and count unchanged.
REQ-038 Build without PC_SEQ_RAS_EN: call + pc_src=11 target=0x400 -> q=0x400, ras_empty=1, ras_err=0.
